alu_xor_issue_stage: RTL and testbench

//  Registered issue/result stage wrapping the 16-bit XOR datapath of the ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/xor_op_unit.sv | 34 +++
 rtl/alu_xor_issue_stage.sv | 106 ++++++++++
 tb/tb_alu_xor_issue_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU XOR issue stage: op encodings, FSM states,
// default widths and reset values.
package alu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_XOR  = 2'b00,
        OP_ACCX = 2'b01,
        OP_CLR  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    localparam stage_state_e RST_STATE = ST_EMPTY;

endpackage

// File: rtl/xor_op_unit.sv
// Combinational XOR operation unit: produces the next result and the next
// accumulator value for one operand beat.
module xor_op_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] acc_o
);

    always_comb begin
        res_o = '0;
        acc_o = acc_i;
        case (alu_op_e'(in_op))
            OP_XOR:  res_o = in_a ^ in_b;
            OP_ACCX: begin
                acc_o = acc_i ^ in_a ^ in_b;
                res_o = acc_i ^ in_a ^ in_b;
            end
            OP_CLR: begin
                acc_o = '0;
                res_o = '0;
            end
            OP_PASS: res_o = in_a;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_xor_issue_stage.sv
// Registered issue/result stage around the XOR datapath with a one-deep result
// register. Optional parity output is enabled by defining ALU_XOR_PARITY_EN.
module alu_xor_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count,
`ifdef ALU_XOR_PARITY_EN
    output logic             out_parity,
`endif
    output stage_state_e     state_dbg
);

    // Handshake: a beat transfers on any rising edge where valid && ready are
    // both high; a source holds valid and payload stable until it transfers.
    stage_state_e     state_q, state_d;
    logic             accept;
    logic [WIDTH-1:0] res_c, acc_c;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    xor_op_unit #(.WIDTH(WIDTH)) u_op (
        .in_a  (in_a),
        .in_b  (in_b),
        .in_op (in_op),
        .acc_i (acc_q),
        .res_o (res_c),
        .acc_o (acc_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RST_STATE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = RST_STATE;
        endcase
    end

    // Same-cycle refill: a draining result frees the register for a new beat.
    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = !out_valid || out_ready;
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        out_r_d = out_r_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept) begin
            out_r_d = res_c;
            acc_d   = acc_c;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            out_r_q <= out_r_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALU_XOR_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         parity_q <= 1'b0;
        else if (accept) parity_q <= ^res_c;
    end

    assign out_parity = parity_q;
`endif

    assign out_r     = out_r_q;
    assign out_zero  = (out_r_q == '0);
    assign op_count  = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_xor_issue_stage.sv
// Self-checking bench for alu_xor_issue_stage: reset, op semantics,
// backpressure, streaming, random handshakes and counter wrap.
module tb_alu_xor_issue_stage;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_r;
    logic          out_zero;
    logic [CW-1:0] op_count;
    stage_state_e  state_dbg;
`ifdef ALU_XOR_PARITY_EN
    logic          out_parity;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_acc;
    int           m_cnt;

    alu_xor_issue_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_zero  (out_zero),
        .op_count  (op_count),
`ifdef ALU_XOR_PARITY_EN
        .out_parity(out_parity),
`endif
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) step();
        rst   = 1'b0;
        m_acc = '0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // Reference model: result of one accepted beat, accumulator and counter
    task automatic model_apply(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, output logic [W-1:0] r);
        if (op == OP_XOR)       r = a ^ b;
        else if (op == OP_ACCX) begin m_acc = m_acc ^ a ^ b; r = m_acc; end
        else if (op == OP_CLR)  begin m_acc = '0; r = '0; end
        else                    r = a;
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic drive_beat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = OP_XOR;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        vectors++; if (out_r !== '0) begin miscompares++; $display("FAIL reset_r: got %h exp 0000", out_r); end
        vectors++; if (out_zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b exp 1", out_zero); end
        vectors++; if (op_count !== '0) begin miscompares++; $display("FAIL reset_cnt: got %0d exp 0", op_count); end
        step();
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
        // Fill the stage (and the accumulator), then reset mid-cycle
        drive_beat(OP_ACCX, 16'h0005, 16'h0000);
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL prefill_valid: got %b exp 1", out_valid); end
        #3 rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b exp 0", out_valid); end
        vectors++; if (out_r !== '0) begin miscompares++; $display("FAIL midreset_r: got %h exp 0000", out_r); end
        vectors++; if (out_zero !== 1'b1) begin miscompares++; $display("FAIL midreset_zero: got %b exp 1", out_zero); end
        vectors++; if (op_count !== '0) begin miscompares++; $display("FAIL midreset_cnt: got %0d exp 0", op_count); end
        step();
        rst   = 1'b0;
        m_acc = '0;
        m_cnt = 0;
    endtask

    task automatic test_xor();
        logic [W-1:0] r;
        out_ready = 1'b1;
        drive_beat(OP_XOR, 16'hF0F0, 16'h0FF0);
        model_apply(OP_XOR, 16'hF0F0, 16'h0FF0, r);
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL xor_valid: got %b exp 1", out_valid); end
        vectors++; if (out_r !== r) begin miscompares++; $display("FAIL xor_r: got %h exp %h", out_r, r); end
        vectors++; if (out_zero !== (r == '0)) begin miscompares++; $display("FAIL xor_zero: got %b exp %b", out_zero, (r == '0)); end
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL xor_cnt: got %0d exp %0d", op_count, m_cnt); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL xor_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_accx();
        logic [1:0]   ops[3] = '{OP_ACCX, OP_ACCX, OP_CLR};
        logic [W-1:0] as[3]  = '{16'h0001, 16'h0003, 16'h0000};
        logic [W-1:0] r;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(ops[i], as[i], 16'h0000);
            model_apply(ops[i], as[i], 16'h0000, r);
            step();
            vectors++; if (out_r !== r) begin miscompares++; $display("FAIL accx_r[%0d]: got %h exp %h", i, out_r, r); end
            vectors++; if (out_zero !== (r == '0)) begin miscompares++; $display("FAIL accx_zero[%0d]: got %b exp %b", i, out_zero, (r == '0)); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL accx_drain: got %b exp 0", out_valid); end
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL accx_cnt: got %0d exp %0d", op_count, m_cnt); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1, b1, a2, b2, r1, r2;
        logic [1:0]   op2;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        op2 = 2'($urandom_range(0, 3));
        out_ready = 1'b0;
        drive_beat(OP_XOR, a1, b1);
        model_apply(OP_XOR, a1, b1, r1);
        step();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid1: got %b exp 1", out_valid); end
        drive_beat(op2, a2, b2);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, in_ready); end
            vectors++; if (out_r !== r1) begin miscompares++; $display("FAIL bp_hold[%0d]: got %h exp %h", i, out_r, r1); end
            step();
        end
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL bp_stall_cnt: got %0d exp %0d", op_count, m_cnt); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
        model_apply(op2, a2, b2, r2);
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid2: got %b exp 1", out_valid); end
        vectors++; if (out_r !== r2) begin miscompares++; $display("FAIL bp_r2: got %h exp %h", out_r, r2); end
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL bp_cnt: got %0d exp %0d", op_count, m_cnt); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup: got %b exp 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] a, b, r, e;
        logic [1:0]   op;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom); b = W'($urandom);
            op = (i < 50) ? 2'(OP_XOR) : 2'($urandom_range(0, 3));
            drive_beat(op, a, b);
            model_apply(op, a, b, r);
            exp_q.push_back(r);
            step();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, out_valid); end
            e = exp_q.pop_front();
            vectors++; if (out_r !== e) begin miscompares++; $display("FAIL stream_r[%0d]: got %h exp %h", i, out_r, e); end
            vectors++; if (out_zero !== (e == '0)) begin miscompares++; $display("FAIL stream_zero[%0d]: got %b exp %b", i, out_zero, (e == '0)); end
`ifdef ALU_XOR_PARITY_EN
            vectors++; if (out_parity !== ^e) begin miscompares++; $display("FAIL stream_parity[%0d]: got %b exp %b", i, out_parity, ^e); end
`endif
        end
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got %b exp 0", out_valid); end
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL stream_cnt: got %0d exp %0d", op_count, m_cnt); end
    endtask

    task automatic test_random_handshake();
        logic [W-1:0] r;
        logic         pred_ready, take, drain;
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 2'($urandom_range(0, 3));
                in_a     = W'($urandom);
                in_b     = W'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            pred_ready = (exp_q.size() == 0) || out_ready;
            vectors++; if (in_ready !== pred_ready) begin miscompares++; $display("FAIL hs_ready[%0d]: got %b exp %b", i, in_ready, pred_ready); end
            take  = in_valid && pred_ready;
            drain = (exp_q.size() != 0) && out_ready;
            if (take) model_apply(in_op, in_a, in_b, r);
            step();
            if (drain) void'(exp_q.pop_front());
            if (take) begin
                exp_q.push_back(r);
                in_valid = 1'b0;
            end
            vectors++; if (out_valid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL hs_valid[%0d]: got %b exp %b", i, out_valid, (exp_q.size() != 0)); end
            if (exp_q.size() != 0) begin
                vectors++; if (out_r !== exp_q[0]) begin miscompares++; $display("FAIL hs_r[%0d]: got %h exp %h", i, out_r, exp_q[0]); end
            end
            vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL hs_cnt[%0d]: got %0d exp %0d", i, op_count, m_cnt); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [W-1:0] r, a;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            a = W'($urandom);
            drive_beat(OP_PASS, a, 16'h0000);
            model_apply(OP_PASS, a, 16'h0000, r);
            step();
        end
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL wrap_preload: got %0d exp %0d", op_count, m_cnt); end
        vectors++; if (out_r !== r) begin miscompares++; $display("FAIL wrap_last_r: got %h exp %h", out_r, r); end
        drive_beat(OP_XOR, 16'h0007, 16'h0000);
        model_apply(OP_XOR, 16'h0007, 16'h0000, r);
        step();
        in_valid = 1'b0;
        vectors++; if (op_count !== m_cnt[CW-1:0]) begin miscompares++; $display("FAIL wrap_cnt: got %0d exp %0d", op_count, m_cnt); end
        vectors++; if (out_r !== r) begin miscompares++; $display("FAIL wrap_r: got %h exp %h", out_r, r); end
`ifdef ALU_XOR_PARITY_EN
        vectors++; if (out_parity !== ^r) begin miscompares++; $display("FAIL wrap_parity: got %b exp %b", out_parity, ^r); end
`endif
        step();
    endtask

    initial begin
        m_acc = '0;
        m_cnt = 0;
        test_reset();
        test_xor();
        test_accx();
        test_backpressure();
        test_streaming();
        test_random_handshake();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
